// File: rtl/enc_sched_pkg.sv
// Shared types, codes and block-length helper for the encoder lane scheduler.
package enc_sched_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned DSEL_W  = 4;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OS_BLK = 2'd1,
        ST_TL_BLK = 2'd2
    } sched_state_e;

    localparam logic [DSEL_W-1:0] D_SEL_TL   = 4'd8;
    localparam logic [DSEL_W-1:0] D_SEL_IDLE = 4'd9;

    localparam logic [1:0] GEN_SPEED_GEN4 = 2'd0;
    localparam logic [1:0] GEN_SPEED_GEN3 = 2'd1;
    localparam logic [1:0] GEN_SPEED_GEN2 = 2'd2;
    localparam logic [1:0] GEN_SPEED_RSVD = 2'd3;

    // One byte per lane, as handed to the encoder.
    typedef struct packed {
        logic [BYTE_W-1:0] lane_1;
        logic [BYTE_W-1:0] lane_0;
    } lane_pair_t;

    // Bytes per symbol block for a gen_speed code; 0 for the reserved code.
    function automatic logic [LEN_W-1:0] blk_len(input logic [1:0] gen_speed);
        case (gen_speed)
            GEN_SPEED_GEN4: blk_len = 5'd1;
            GEN_SPEED_GEN3: blk_len = 5'd16;
            GEN_SPEED_GEN2: blk_len = 5'd8;
            default:        blk_len = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/enc_sched_arb.sv
// Block-boundary arbiter: ordered sets win unless their burst limit is reached
// while transport is waiting.
module enc_sched_arb
    import enc_sched_pkg::*;
#(
    parameter int unsigned OS_BURST_MAX = 4
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_boundary,
    input  logic i_gen_ok,
    input  logic i_os_valid,
    input  logic i_tl_valid,
    output logic o_grant_os_c,
    output logic o_grant_tl_c
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(OS_BURST_MAX);

    logic [BURST_W-1:0] r_burst_cnt;
    logic               w_limit;

    assign w_limit = (r_burst_cnt == BURST_LIM);

    // Combinational grant, only meaningful on an enabled block boundary.
    always_comb begin
        o_grant_os_c = 1'b0;
        o_grant_tl_c = 1'b0;
        if (i_enable && i_boundary && i_gen_ok) begin
            if (i_os_valid && !(w_limit && i_tl_valid)) begin
                o_grant_os_c = 1'b1;
            end else if (i_tl_valid) begin
                o_grant_tl_c = 1'b1;
            end
        end
    end

    // Consecutive ordered-set grant counter, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= '0;
        end else if (!i_enable) begin
            r_burst_cnt <= '0;
        end else if (i_boundary) begin
            if (o_grant_os_c) begin
                if (!w_limit) begin
                    r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                end
            end else if (o_grant_tl_c) begin
                r_burst_cnt <= '0;
            end else if (!i_tl_valid) begin
                r_burst_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/enc_lane_scheduler.sv
// Two-lane byte scheduler in front of the encoder: owns whole symbol blocks,
// holds d_sel per block and pads underruns. Optional counters: ENC_SCHED_STATS_EN.
module enc_lane_scheduler
    import enc_sched_pkg::*;
#(
    parameter int unsigned OS_BURST_MAX = 4,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
)(
    input  logic        enc_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  gen_speed,
    input  logic        os_valid,
    output logic        os_ready,
    input  logic [3:0]  os_type,
    input  logic [7:0]  os_lane_0,
    input  logic [7:0]  os_lane_1,
    input  logic        tl_valid,
    output logic        tl_ready,
    input  logic [7:0]  tl_lane_0,
    input  logic [7:0]  tl_lane_1,
    output logic [7:0]  lane_0_tx,
    output logic [7:0]  lane_1_tx,
    output logic [3:0]  d_sel,
    output logic        enc_en,
    output logic        blk_first
`ifdef ENC_SCHED_STATS_EN
    ,
    output logic [15:0] underrun_cnt,
    output logic [15:0] os_blk_cnt
`endif
);

    sched_state_e      r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    lane_pair_t        r_lanes, w_lanes_nxt;
    logic [DSEL_W-1:0] r_d_sel, w_d_sel_nxt;
    logic              r_enc_en, w_enc_en_nxt;
    logic              r_blk_first, w_blk_first_nxt;

    logic              w_boundary, w_last, w_gen_ok, w_pad;
    logic              w_grant_os, w_grant_tl;
    logic              w_os_ready, w_tl_ready;
    logic [LEN_W-1:0]  w_len_new;
    lane_pair_t        w_os_bytes, w_tl_bytes, w_pad_bytes;

    assign w_boundary  = (r_idx == '0);
    assign w_len_new   = blk_len(gen_speed);
    assign w_gen_ok    = (gen_speed != GEN_SPEED_RSVD);
    assign w_last      = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    assign w_os_bytes  = {os_lane_1, os_lane_0};
    assign w_tl_bytes  = {tl_lane_1, tl_lane_0};
    assign w_pad_bytes = {PAD_BYTE, PAD_BYTE};

    // Owner has nothing to give mid-block: a pad byte keeps the block length.
    assign w_pad = enable && !w_boundary &&
                   (((r_state == ST_OS_BLK) && !os_valid) ||
                    ((r_state == ST_TL_BLK) && !tl_valid));

    enc_sched_arb #(
        .OS_BURST_MAX (OS_BURST_MAX)
    ) u_arb (
        .clk          (enc_clk),
        .rst_n        (rst),
        .i_enable     (enable),
        .i_boundary   (w_boundary),
        .i_gen_ok     (w_gen_ok),
        .i_os_valid   (os_valid),
        .i_tl_valid   (tl_valid),
        .o_grant_os_c (w_grant_os),
        .o_grant_tl_c (w_grant_tl)
    );

    // Next state, block index and next output bytes; readys are combinational.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_len_nxt       = r_len;
        w_lanes_nxt     = r_lanes;
        w_d_sel_nxt     = r_d_sel;
        w_enc_en_nxt    = r_enc_en;
        w_blk_first_nxt = 1'b0;
        w_os_ready      = 1'b0;
        w_tl_ready      = 1'b0;

        if (!enable) begin
            w_state_nxt  = ST_IDLE;
            w_idx_nxt    = '0;
            w_lanes_nxt  = '0;
            w_d_sel_nxt  = D_SEL_IDLE;
            w_enc_en_nxt = 1'b0;
        end else if (w_boundary) begin
            w_os_ready   = w_grant_os;
            w_tl_ready   = w_grant_tl;
            w_enc_en_nxt = 1'b1;
            if (w_grant_os || w_grant_tl) begin
                w_state_nxt     = w_grant_os ? ST_OS_BLK : ST_TL_BLK;
                w_len_nxt       = w_len_new;
                w_idx_nxt       = (w_len_new == LEN_W'(1)) ? '0 : IDX_W'(1);
                w_lanes_nxt     = w_grant_os ? w_os_bytes : w_tl_bytes;
                w_d_sel_nxt     = w_grant_os ? os_type : D_SEL_TL;
                w_blk_first_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_lanes_nxt = '0;
                w_d_sel_nxt = D_SEL_IDLE;
            end
        end else begin
            w_enc_en_nxt = 1'b1;
            w_idx_nxt    = w_last ? '0 : (r_idx + IDX_W'(1));
            case (r_state)
                ST_OS_BLK: begin
                    w_os_ready  = 1'b1;
                    w_lanes_nxt = w_pad ? w_pad_bytes : w_os_bytes;
                end
                ST_TL_BLK: begin
                    w_tl_ready  = 1'b1;
                    w_lanes_nxt = w_pad ? w_pad_bytes : w_tl_bytes;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_lanes_nxt = '0;
                    w_d_sel_nxt = D_SEL_IDLE;
                end
            endcase
        end
    end

    assign os_ready = w_os_ready & rst;
    assign tl_ready = w_tl_ready & rst;

    // State and registered encoder-facing outputs.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_lanes     <= '0;
            r_d_sel     <= D_SEL_IDLE;
            r_enc_en    <= 1'b0;
            r_blk_first <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_lanes     <= w_lanes_nxt;
            r_d_sel     <= w_d_sel_nxt;
            r_enc_en    <= w_enc_en_nxt;
            r_blk_first <= w_blk_first_nxt;
        end
    end

    assign lane_0_tx = r_lanes.lane_0;
    assign lane_1_tx = r_lanes.lane_1;
    assign d_sel     = r_d_sel;
    assign enc_en    = r_enc_en;
    assign blk_first = r_blk_first;

`ifdef ENC_SCHED_STATS_EN
    logic [STAT_W-1:0] r_underrun_cnt;
    logic [STAT_W-1:0] r_os_blk_cnt;

    // Pad-byte counter (saturating, cleared while disabled) and OS grant counter.
    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            r_underrun_cnt <= '0;
            r_os_blk_cnt   <= '0;
        end else begin
            if (!enable) begin
                r_underrun_cnt <= '0;
            end else if (w_pad && (r_underrun_cnt != '1)) begin
                r_underrun_cnt <= r_underrun_cnt + STAT_W'(1);
            end
            if (w_grant_os) begin
                r_os_blk_cnt <= r_os_blk_cnt + STAT_W'(1);
            end
        end
    end

    assign underrun_cnt = r_underrun_cnt;
    assign os_blk_cnt   = r_os_blk_cnt;
`endif

endmodule

// File: doc/enc_lane_scheduler.md
# enc_lane_scheduler

Sequences the two-lane byte stream that feeds the encoding block. It arbitrates between the ordered-set generator and the transport layer on symbol-block boundaries and locks the winner for a whole block (8 bytes at Gen2, 16 at Gen3, 1 at Gen4). It drives `d_sel` so every block is encoded with one consistent sync header, and it pads underruns so block alignment never slips. It sits between the ordered-set/transport sources and the encoder's `lane_0_tx`/`lane_1_tx`/`d_sel`/`enable` inputs.

## Interface
- `OS_BURST_MAX`, 4: max consecutive ordered-set blocks granted while transport is waiting (1..15).
- `PAD_BYTE`, 8'h00: byte inserted on underrun.
- `enc_clk`  in  1  encoder clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  scheduler enable; low = synchronous abort to IDLE.
- `gen_speed`  in  2  0 = Gen4 (1-byte block), 1 = Gen3 (16), 2 = Gen2 (8), 3 = reserved (no grants).
- `os_valid`, `os_ready`  in, out  1  ordered-set source handshake.
- `os_type`  in  4  `d_sel` code for the OS block (1..7); sampled at grant.
- `os_lane_0`, `os_lane_1`  in  8  OS bytes per lane.
- `tl_valid`, `tl_ready`  in, out  1  transport source handshake.
- `tl_lane_0`, `tl_lane_1`  in  8  transport bytes per lane.
- `lane_0_tx`, `lane_1_tx`  out  8  registered bytes to encoder.
- `d_sel`  out  4  8 = transport, 1..7 = OS type, 9 = idle.
- `enc_en`  out  1  encoder enable.
- `blk_first`  out  1  high on the first byte of each block.

## Operation
- FSM states: IDLE, OS_BLK, TL_BLK.
- Block length `L` and `gen_speed` are latched at grant. Changes mid-block take effect at the next boundary.
- Boundary (byte index 0) arbitration:
  - `os_valid` wins, unless `burst_cnt == OS_BURST_MAX` and `tl_valid`; then TL wins.
  - Otherwise `tl_valid` wins.
  - If neither is valid, or `gen_speed == 3`, emit an idle cycle: `d_sel = 9`, bytes 0, index stays 0.
- `burst_cnt`: increments on each OS grant and saturates at `OS_BURST_MAX`. Clears on a TL grant, and on any idle boundary when `tl_valid` is low.
- In OS_BLK/TL_BLK only the owner's ready is high (combinational: state, index, `enable`). The other source's ready is 0.
- A byte is accepted on `valid && ready`.
- Underrun (owner valid low mid-block): load `PAD_BYTE` on both lanes and advance the index anyway. The block always completes in exactly `L` cycles.
- The index wraps `L-1 -> 0`; at 0 the next arbitration happens in the same cycle (back-to-back blocks, no bubble).
- `d_sel` is loaded with the first byte of the block and held constant for all `L` bytes. It is `os_type` for OS blocks and 8 for TL blocks.
- `enc_en` = 1 in any non-IDLE cycle and on idle cycles while `enable` is high. It is 0 when `enable` is low.
- `enable` low: next edge forces IDLE, clears the index and `burst_cnt`, zeroes the bytes, sets `d_sel = 9` and `enc_en = 0`. Both readys drop combinationally in the same cycle. Any partial block is discarded.
- Simultaneous `os_valid` and `tl_valid` at a boundary: OS wins unless the burst limit is hit.

## Timing
- Reset values:
  - `lane_0_tx`, `lane_1_tx` = 0
  - `d_sel` = 9
  - `enc_en` = 0
  - `blk_first` = 0
  - `os_ready`, `tl_ready` = 0
  - FSM = IDLE, index = 0, `burst_cnt` = 0
- Latency: a byte accepted at edge N appears on `lane_*_tx` after edge N (one register stage).
- `blk_first` is registered and aligned with the first output byte of each block.
- Block throughput: `L` cycles per block. Grant-to-first-byte is 1 cycle.
- Reset is asynchronous on assertion. Deassertion is consumed by the first edge; first arbitration happens on that edge.

## Configuration
- `ENC_SCHED_STATS_EN` defined:
  - Adds output `underrun_cnt` (16-bit, saturating), counting pad bytes inserted. Reset 0; cleared when `enable` is low.
  - Adds output `os_blk_cnt` (16-bit, wrapping), counting OS grants.
- Undefined: neither port nor counter exists. Scheduling behaviour is identical in both builds.

## Structure
- Shared package `enc_sched_pkg` holds:
  - the state enum;
  - `D_SEL_TL = 4'd8` and `D_SEL_IDLE = 4'd9`;
  - the `gen_speed` codes;
  - the function `blk_len(gen_speed)` returning 1/16/8/0.
- Sub-module `enc_sched_arb`: boundary arbiter with `burst_cnt` and `OS_BURST_MAX` limiting. Combinational grant plus the burst register.

## Test plan
- Gen2, `tl_valid` held with bytes 0x10.. → 8 outputs 0x10..0x17 with `d_sel = 8`. `blk_first` is high on 0x10 only. The next block starts with no bubble.
- Gen3, `os_valid` and `tl_valid` both held, `OS_BURST_MAX = 4` → grant pattern OS,OS,OS,OS,TL repeating. OS blocks carry `d_sel = os_type` for 16 cycles each.
- Gen2 TL block, `tl_valid` dropped at byte 3 for 2 cycles → bytes 3–4 are 0x00. The block still ends at cycle 8. With the macro, `underrun_cnt = 2`.
- `gen_speed` switched 2→1 at byte 5 → the current block finishes with 8 bytes, and the next block is 16 bytes.
- `enable` dropped mid-block at index 6 → readys are 0 in the same cycle. The next edge gives `d_sel = 9`, `enc_en = 0`, bytes 0. Re-enable starts arbitration at index 0.
- Reset asserted mid-OS-block → all outputs at reset values immediately. First block after release is arbitrated fresh with `burst_cnt = 0`.
